// File: rtl/prog_counter.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate mode,
// enable prescaler, synchronous load/clear, terminal-count pulse and sticky overflow.
module prog_counter #(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX      = WIDTH'(MOD_MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] load_clamped;
  logic             step;
  logic             at_top;
  logic             at_bottom;

  // Clamping is only needed when the modulus leaves unreachable codes.
  if (MOD_MAX < 2**WIDTH - 1) begin : g_clamp
    assign load_clamped = (load_val > MAX) ? MAX : load_val;
  end else begin : g_no_clamp
    assign load_clamped = load_val;
  end

  assign step      = enable && (pre_cnt == PRE_LAST);
  assign at_top    = (count == MAX);
  assign at_bottom = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      count   <= load_clamped;
      pre_cnt <= '0;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (step) begin
        pre_cnt <= '0;
        if (up) begin
          if (at_top) begin
            count <= (SATURATE != 0) ? MAX : '0;
            tc    <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (at_bottom) begin
            count <= (SATURATE != 0) ? '0 : MAX;
            tc    <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end else if (enable) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: four configurations share one stimulus stream and are
// checked each cycle against a behavioural model, plus hand-computed expectations.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst, enable, up, load, clear;
  logic [7:0] load_val;

  logic [7:0] d_count [4];
  logic       d_tc    [4];
  logic       d_ovf   [4];

  always #5 clk = ~clk;

  // 0: defaults, 1: mod 9 wrap, 2: mod 9 saturate, 3: prescale 4
  prog_counter #(.WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .count(d_count[0]), .tc(d_tc[0]), .ovf(d_ovf[0]));
  prog_counter #(.WIDTH(8), .MOD_MAX(9)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .count(d_count[1]), .tc(d_tc[1]), .ovf(d_ovf[1]));
  prog_counter #(.WIDTH(8), .MOD_MAX(9), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .count(d_count[2]), .tc(d_tc[2]), .ovf(d_ovf[2]));
  prog_counter #(.WIDTH(8), .PRESCALE(4)) u3 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .count(d_count[3]), .tc(d_tc[3]), .ovf(d_ovf[3]));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model
  int modv [4] = '{255, 9, 9, 255};
  int presv[4] = '{1, 1, 1, 4};
  int satv [4] = '{0, 0, 1, 0};
  int m_count[4];
  int m_pre  [4];
  int m_tc   [4];
  int m_ovf  [4];
  bit started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clear) begin
        m_count[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_count[i] = (int'(load_val) > modv[i]) ? modv[i] : int'(load_val);
        m_pre[i] = 0; m_tc[i] = 0;
      end else if (enable && m_pre[i] + 1 == presv[i]) begin
        m_pre[i] = 0;
        if (up) begin
          m_tc[i] = (m_count[i] == modv[i]) ? 1 : 0;
          if (m_tc[i] == 1 && satv[i] == 1) m_count[i] = modv[i];
          else m_count[i] = (m_count[i] + 1) % (modv[i] + 1);
        end else begin
          m_tc[i] = (m_count[i] == 0) ? 1 : 0;
          if (m_tc[i] == 1 && satv[i] == 1) m_count[i] = 0;
          else m_count[i] = (m_count[i] + modv[i]) % (modv[i] + 1);
        end
        if (m_tc[i] == 1) m_ovf[i] = 1;
      end else begin
        if (enable) m_pre[i] = m_pre[i] + 1;
        m_tc[i] = 0;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model_count[%0d]", i), 32'(d_count[i]), 32'(m_count[i]));
        check($sformatf("model_tc[%0d]", i),    32'(d_tc[i]),    32'(m_tc[i]));
        check($sformatf("model_ovf[%0d]", i),   32'(d_ovf[i]),   32'(m_ovf[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; clear = 1'b0; load_val = '0;
    tick(); tick();
    check("rst_count0", 32'(d_count[0]), 0);
    check("rst_tc0", 32'(d_tc[0]), 0);
    check("rst_ovf0", 32'(d_ovf[0]), 0);

    // Basic counting
    rst = 1'b0; enable = 1'b1; up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("basic_count_%0d", k), 32'(d_count[0]), 32'(k));
    end
    check("basic_ovf0", 32'(d_ovf[0]), 0);

    // Prescaler: steps at enabled cycles 4, 8, 12
    enable = 1'b0; clear = 1'b1; tick(); clear = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3)      check("pre_before_first", 32'(d_count[3]), 0);
      if (k % 4 == 0)  check($sformatf("pre_step_%0d", k), 32'(d_count[3]), 32'(k / 4));
    end
    tick(); tick();
    enable = 1'b0; tick(); tick(); tick();
    check("pre_hold", 32'(d_count[3]), 3);
    enable = 1'b1; tick();
    check("pre_resume1", 32'(d_count[3]), 3);
    tick();
    check("pre_resume2", 32'(d_count[3]), 4);

    // Wrap up then down, modulus 9
    enable = 1'b0; clear = 1'b1; tick();
    clear = 1'b0; load = 1'b1; load_val = 8'd8; tick();
    check("wrap_load8", 32'(d_count[1]), 8);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    tick(); check("wrap_9", 32'(d_count[1]), 9); check("wrap_9_tc", 32'(d_tc[1]), 0);
    tick(); check("wrap_0", 32'(d_count[1]), 0); check("wrap_0_tc", 32'(d_tc[1]), 1);
    check("wrap_ovf", 32'(d_ovf[1]), 1);
    tick(); check("wrap_1", 32'(d_count[1]), 1); check("wrap_1_tc", 32'(d_tc[1]), 0);
    up = 1'b0;
    tick(); check("down_0", 32'(d_count[1]), 0);
    tick(); check("down_9", 32'(d_count[1]), 9); check("down_9_tc", 32'(d_tc[1]), 1);

    // Saturate at 9
    enable = 1'b0; load = 1'b1; load_val = 8'd9; tick();
    check("sat_load9_tc", 32'(d_tc[2]), 0);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("sat_hold_%0d", k), 32'(d_count[2]), 9);
      check($sformatf("sat_tc_%0d", k), 32'(d_tc[2]), 1);
    end
    check("sat_ovf", 32'(d_ovf[2]), 1);
    enable = 1'b0; clear = 1'b1; tick();
    check("sat_clear_count", 32'(d_count[2]), 0);
    check("sat_clear_ovf", 32'(d_ovf[2]), 0);
    clear = 1'b0;

    // Priority and clamp
    load = 1'b1; load_val = 8'd200; tick();
    check("clamp_mod9", 32'(d_count[1]), 9);
    check("noclamp_def", 32'(d_count[0]), 200);
    load_val = 8'd5; enable = 1'b1; tick();
    check("load_beats_step", 32'(d_count[0]), 5);
    load = 1'b0; tick();
    check("step_after_load", 32'(d_count[0]), 6);
    check("pre_restart_on_load", 32'(d_count[3]), 5);
    clear = 1'b1; load = 1'b1; load_val = 8'd7; tick();
    check("clear_beats_load", 32'(d_count[1]), 0);
    clear = 1'b0; load = 1'b0; enable = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("pre_ovf_setup", 32'(d_ovf[1]), 1);
    rst = 1'b1; tick();
    check("rst_mid_count", 32'(d_count[1]), 0);
    check("rst_mid_ovf", 32'(d_ovf[1]), 0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("rst_pre_discard", 32'(d_count[3]), 0);
    tick();
    check("rst_pre_first", 32'(d_count[3]), 1);

    // Mixed traffic against the model
    for (int k = 0; k < 300; k++) begin
      enable   = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 1) == 1);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      clear    = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
